// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, vend validation, dispense handshake, change payout.
// Optional macro VEND_INPUT_SYNC_EN adds 2-flop synchronizers on coin/vend/cancel/disp_done.
module vend_sequencer #(
    parameter int unsigned CREDIT_W  = 3,
    parameter int unsigned PRICE     = 3,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CHG_PULSE = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ena,
    input  logic                i_coin,
    input  logic                i_vend,
    input  logic                i_cancel,
    input  logic [2:0]          i_sel,
    input  logic                i_disp_done,
    output logic                o_disp_req,
    output logic [2:0]          o_product,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_accepted,
    output logic                o_coin_reject,
    output logic                o_change_out,
    output logic                o_busy,
    output logic                o_fault
);

    localparam int unsigned CNT_MAX = (TIMEOUT > CHG_PULSE) ? TIMEOUT : CHG_PULSE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CNT_W-1:0]    TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    PHASE_LAST = CNT_W'(CHG_PULSE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDispense,
        StChange,
        StFault
    } state_e;

    state_e                r_state, w_state_nxt;
    logic [CREDIT_W-1:0]   r_credit, w_credit_nxt;
    logic [2:0]            r_product, w_product_nxt;
    logic                  r_disp_req, w_disp_req_nxt;
    logic                  r_accepted, w_accepted_nxt;
    logic                  r_coin_reject, w_coin_reject_nxt;
    logic                  r_change_out, w_change_out_nxt;
    logic                  r_fault, w_fault_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

    logic w_coin, w_vend, w_cancel, w_done;
    logic r_coin_q, r_vend_q, r_cancel_q;
    logic w_coin_edge, w_vend_edge, w_cancel_edge, w_vend_ok;

`ifdef VEND_INPUT_SYNC_EN
    logic [3:0] r_sync1, r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_coin, i_vend, i_cancel, i_disp_done};
            r_sync2 <= r_sync1;
        end
    end

    assign {w_coin, w_vend, w_cancel, w_done} = r_sync2;
`else
    assign {w_coin, w_vend, w_cancel, w_done} = {i_coin, i_vend, i_cancel, i_disp_done};
`endif

    assign w_coin_edge   = w_coin & ~r_coin_q;
    assign w_vend_edge   = w_vend & ~r_vend_q;
    assign w_cancel_edge = w_cancel & ~r_cancel_q;
    assign w_vend_ok     = w_vend_edge && (i_sel != 3'd0) && (r_credit >= PRICE_C);

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_product_nxt     = r_product;
        w_disp_req_nxt    = r_disp_req;
        w_accepted_nxt    = 1'b0;
        w_coin_reject_nxt = 1'b0;
        w_change_out_nxt  = r_change_out;
        w_fault_nxt       = r_fault;
        w_cnt_nxt         = r_cnt;

        unique case (r_state)
            StIdle, StAccum: begin
                if (w_cancel_edge && (r_credit != '0)) begin
                    w_state_nxt       = StChange;
                    w_change_out_nxt  = 1'b1;
                    w_cnt_nxt         = '0;
                    w_coin_reject_nxt = w_coin_edge;
                end else begin
                    // Saturation is judged on the pre-vend credit.
                    if (w_coin_edge) begin
                        if (r_credit != CREDIT_MAX) begin
                            w_accepted_nxt = 1'b1;
                            w_credit_nxt   = r_credit + 1'b1;
                        end else begin
                            w_coin_reject_nxt = 1'b1;
                        end
                    end
                    if (w_vend_ok) begin
                        w_credit_nxt   = w_credit_nxt - PRICE_C;
                        w_product_nxt  = i_sel;
                        w_disp_req_nxt = 1'b1;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = StDispense;
                    end else begin
                        w_state_nxt = (w_credit_nxt != '0) ? StAccum : StIdle;
                    end
                end
            end
            StDispense: begin
                w_coin_reject_nxt = w_coin_edge;
                if (w_done) begin
                    w_disp_req_nxt = 1'b0;
                    if (r_credit != '0) begin
                        w_state_nxt      = StChange;
                        w_change_out_nxt = 1'b1;
                        w_cnt_nxt        = '0;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_disp_req_nxt = 1'b0;
                    w_fault_nxt    = 1'b1;
                    w_state_nxt    = StFault;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StChange: begin
                w_coin_reject_nxt = w_coin_edge;
                if (r_cnt == PHASE_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_change_out) begin
                        w_change_out_nxt = 1'b0;
                        w_credit_nxt     = r_credit - 1'b1;
                    end else if (r_credit == '0) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_change_out_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StFault: begin
                w_coin_reject_nxt = w_coin_edge;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_coin_q      <= 1'b0;
            r_vend_q      <= 1'b0;
            r_cancel_q    <= 1'b0;
            r_state       <= StIdle;
            r_credit      <= '0;
            r_product     <= '0;
            r_disp_req    <= 1'b0;
            r_accepted    <= 1'b0;
            r_coin_reject <= 1'b0;
            r_change_out  <= 1'b0;
            r_fault       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // Edge detectors run regardless of ena, so edges during ena=0 are dropped.
            r_coin_q   <= w_coin;
            r_vend_q   <= w_vend;
            r_cancel_q <= w_cancel;
            if (i_ena) begin
                r_state       <= w_state_nxt;
                r_credit      <= w_credit_nxt;
                r_product     <= w_product_nxt;
                r_disp_req    <= w_disp_req_nxt;
                r_accepted    <= w_accepted_nxt;
                r_coin_reject <= w_coin_reject_nxt;
                r_change_out  <= w_change_out_nxt;
                r_fault       <= w_fault_nxt;
                r_cnt         <= w_cnt_nxt;
            end
        end
    end

    assign o_disp_req    = r_disp_req;
    assign o_product     = r_product;
    assign o_credit      = r_credit;
    assign o_accepted    = r_accepted;
    assign o_coin_reject = r_coin_reject;
    assign o_change_out  = r_change_out;
    assign o_fault       = r_fault;
    assign o_busy        = (r_state == StDispense) || (r_state == StChange) || (r_state == StFault);

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_vend_sequencer;

    localparam int unsigned CW    = 3;
    localparam int unsigned PRICE = 3;
    localparam int unsigned TMO   = 16;
    localparam int unsigned CP    = 4;
    localparam int unsigned CMAX  = 7;

    localparam int M_IDLE  = 0;
    localparam int M_DISP  = 1;
    localparam int M_CHG   = 2;
    localparam int M_FAULT = 3;

    logic          clk = 1'b0;
    logic          rst_n, ena, coin, vend, cancel, disp_done;
    logic [2:0]    sel;
    logic          disp_req, accepted, coin_reject, change_out, busy, fault;
    logic [2:0]    product;
    logic [CW-1:0] credit;

    always #5 clk = ~clk;

    vend_sequencer #(
        .CREDIT_W  (CW),
        .PRICE     (PRICE),
        .TIMEOUT   (TMO),
        .CHG_PULSE (CP)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ena         (ena),
        .i_coin        (coin),
        .i_vend        (vend),
        .i_cancel      (cancel),
        .i_sel         (sel),
        .i_disp_done   (disp_done),
        .o_disp_req    (disp_req),
        .o_product     (product),
        .o_credit      (credit),
        .o_accepted    (accepted),
        .o_coin_reject (coin_reject),
        .o_change_out  (change_out),
        .o_busy        (busy),
        .o_fault       (fault)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a transaction mode plus elapsed-cycle counters; outputs derived from them.
    int m_mode, m_credit, m_product, m_wait, m_t;
    bit m_acc, m_rej, m_cq, m_vq, m_xq;

    task automatic model_step();
        bit ce, ve, xe, ok;
        int c, pos;
        if (!rst_n) begin
            m_mode = M_IDLE; m_credit = 0; m_product = 0; m_wait = 0; m_t = 0;
            m_acc = 0; m_rej = 0; m_cq = 0; m_vq = 0; m_xq = 0;
            return;
        end
        ce = coin && !m_cq;
        ve = vend && !m_vq;
        xe = cancel && !m_xq;
        m_cq = coin; m_vq = vend; m_xq = cancel;
        if (!ena) return;
        m_acc = 0;
        m_rej = 0;
        case (m_mode)
            M_IDLE: begin
                if (xe && m_credit > 0) begin
                    m_mode = M_CHG; m_t = 0; m_rej = ce;
                end else begin
                    c  = m_credit;
                    ok = ve && (sel != 0) && (m_credit >= PRICE);
                    if (ce) begin
                        if (m_credit < CMAX) begin m_acc = 1; c = c + 1; end
                        else m_rej = 1;
                    end
                    if (ok) begin
                        c = c - PRICE; m_product = sel; m_mode = M_DISP; m_wait = 0;
                    end
                    m_credit = c;
                end
            end
            M_DISP: begin
                m_rej = ce;
                if (disp_done) begin
                    m_mode = (m_credit > 0) ? M_CHG : M_IDLE; m_t = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) m_mode = M_FAULT;
                end
            end
            M_CHG: begin
                m_rej = ce;
                pos = m_t % (2 * CP);
                if (pos == CP - 1) m_credit--;
                if (pos == 2 * CP - 1 && m_credit == 0) m_mode = M_IDLE;
                else m_t++;
            end
            default: m_rej = ce;
        endcase
    endtask

    int n_acc, n_rej, n_rise, n_high;
    bit prev_chg;

    task automatic tick();
        bit exp_chg;
        model_step();
        @(posedge clk);
        #1;
        exp_chg = (m_mode == M_CHG) && (((m_t / CP) % 2) == 0);
        check_eq("credit", credit, m_credit);
        check_eq("product", product, m_product);
        check_eq("accepted", accepted, m_acc);
        check_eq("coin_reject", coin_reject, m_rej);
        check_eq("change_out", change_out, exp_chg);
        check_eq("disp_req", disp_req, m_mode == M_DISP);
        check_eq("fault", fault, m_mode == M_FAULT);
        check_eq("busy", busy, m_mode != M_IDLE);
        if (accepted) n_acc++;
        if (coin_reject) n_rej++;
        if (change_out) n_high++;
        if (change_out && !prev_chg) n_rise++;
        prev_chg = change_out;
    endtask

    task automatic do_reset();
        coin = 0; vend = 0; cancel = 0; disp_done = 0; sel = 0; ena = 1;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        n_acc = 0; n_rej = 0; n_rise = 0; n_high = 0;
    endtask

    task automatic coin_pulse();
        coin = 1; tick();
        coin = 0; tick();
    endtask

    task automatic vend_pulse(input logic [2:0] s);
        sel = s;
        vend = 1; tick();
        vend = 0; tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        prev_chg = 0;
        do_reset();
        check_eq("rst_credit", credit, 0);
        check_eq("rst_busy", busy, 0);

        // Coin saturation
        repeat (8) coin_pulse();
        check_eq("sat_credit", credit, 7);
        check_eq("sat_acc_count", n_acc, 7);
        check_eq("sat_rej_count", n_rej, 1);

        // Vend with change
        do_reset();
        repeat (5) coin_pulse();
        sel = 2; vend = 1; tick();
        check_eq("vend_product", product, 2);
        check_eq("vend_credit", credit, 2);
        check_eq("vend_req", disp_req, 1);
        vend = 0; tick();
        disp_done = 1; tick();
        disp_done = 0;
        check_eq("done_req", disp_req, 0);
        check_eq("done_chg", change_out, 1);
        repeat (20) tick();
        check_eq("chg_pulses", n_rise, 2);
        check_eq("chg_high_cycles", n_high, 8);
        check_eq("chg_credit", credit, 0);
        check_eq("chg_busy", busy, 0);

        // Rejected vends
        do_reset();
        repeat (2) coin_pulse();
        vend_pulse(3'd5);
        check_eq("low_credit_req", disp_req, 0);
        check_eq("low_credit_credit", credit, 2);
        do_reset();
        repeat (3) coin_pulse();
        vend_pulse(3'd0);
        check_eq("nosel_req", disp_req, 0);
        check_eq("nosel_credit", credit, 3);

        // Coin and vend together
        do_reset();
        repeat (3) coin_pulse();
        sel = 4; coin = 1; vend = 1; tick();
        check_eq("cv_credit", credit, 1);
        check_eq("cv_acc", accepted, 1);
        check_eq("cv_req", disp_req, 1);
        coin = 0; vend = 0; tick();
        disp_done = 1; tick();
        disp_done = 0;
        repeat (12) tick();
        check_eq("cv_end_busy", busy, 0);
        check_eq("cv_end_credit", credit, 0);

        // Cancel and coin together
        do_reset();
        repeat (2) coin_pulse();
        coin = 1; cancel = 1; tick();
        check_eq("cc_rej", coin_reject, 1);
        check_eq("cc_busy", busy, 1);
        check_eq("cc_chg", change_out, 1);
        coin = 0; cancel = 0;
        repeat (20) tick();
        check_eq("cc_pulses", n_rise, 2);
        check_eq("cc_credit", credit, 0);

        // Timeout into sticky fault
        do_reset();
        repeat (3) coin_pulse();
        sel = 1; vend = 1; tick();
        vend = 0;
        repeat (15) tick();
        check_eq("tmo_req_before", disp_req, 1);
        check_eq("tmo_fault_before", fault, 0);
        tick();
        check_eq("tmo_req", disp_req, 0);
        check_eq("tmo_fault", fault, 1);
        coin = 1; tick();
        check_eq("fault_coin_rej", coin_reject, 1);
        coin = 0;
        repeat (5) tick();
        check_eq("fault_sticky", fault, 1);
        do_reset();
        check_eq("fault_cleared", fault, 0);

        // Reset during the second change pulse
        repeat (2) coin_pulse();
        cancel = 1; tick();
        cancel = 0; tick();
        repeat (7) tick();
        check_eq("mid_chg_high", change_out, 1);
        rst_n = 0; tick();
        check_eq("abort_chg", change_out, 0);
        check_eq("abort_credit", credit, 0);
        check_eq("abort_busy", busy, 0);
        rst_n = 1;

        // ena freeze mid-CHANGE
        do_reset();
        repeat (3) coin_pulse();
        cancel = 1; tick();
        cancel = 0; tick();
        tick();
        ena = 0;
        repeat (10) tick();
        check_eq("frz_chg", change_out, 1);
        check_eq("frz_credit", credit, 3);
        ena = 1;
        tick();
        check_eq("resume_chg_c4", change_out, 1);
        tick();
        check_eq("resume_chg_c5", change_out, 0);
        check_eq("resume_credit", credit, 2);
        repeat (30) tick();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) coin = ~coin;
            if ($urandom_range(0, 5) == 0) vend = ~vend;
            if ($urandom_range(0, 15) == 0) cancel = ~cancel;
            if ($urandom_range(0, 7) == 0) sel = 3'($urandom_range(0, 7));
            disp_done = ($urandom_range(0, 5) == 0);
            ena = ($urandom_range(0, 9) != 0);
            if (m_mode == M_FAULT) rst_n = ($urandom_range(0, 9) != 0);
            else rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Transaction controller for the vending-machine FSM datapath.
- Counts coin pulses into a saturating credit register and validates product selection against a fixed price.
- Drives the dispenser mechanism through a req/done handshake with timeout, then pays out change as timed pulses.
- Sits between the debounced front-panel inputs and the dispense/credit outputs of the top-level wrapper.

Parameters:
- CREDIT_W, 3, width of the credit register; maximum credit is 2^CREDIT_W-1.
- PRICE, 3, credit units consumed per vend; legal range 1..2^CREDIT_W-1.
- TIMEOUT, 255, cycles to wait for disp_done before declaring a fault.
- CHG_PULSE, 4, cycles per high phase and per low phase of change_out.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  clock enable; 0 freezes FSM, counters and outputs.
- coin  in  1  coin level; a rising edge is one credit unit.
- vend  in  1  vend button level; acts on its rising edge.
- cancel  in  1  cancel button level; acts on its rising edge.
- sel  in  3  product code; 0 means none, 1..7 are valid.
- disp_done  in  1  dispenser completion strobe.
- disp_req  out  1  dispense request.
- product  out  3  code of the last product vended.
- credit  out  CREDIT_W  current credit.
- accepted  out  1  one-cycle pulse when a coin is counted.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- change_out  out  1  change payout pulse train.
- busy  out  1  high in DISPENSE, CHANGE and FAULT.
- fault  out  1  high while in FAULT.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs are 0, credit=0, product=0. Edge-detector registers are cleared to 0.
- Edge detection:
  - coin, vend and cancel are each registered once; edge = in & ~in_q.
  - Detector registers update even when ena=0, so edges that occur during ena=0 are lost.
- Latency: an edge sampled at clock edge n updates credit/state/pulses at edge n. Results are visible in the following cycle.
- IDLE / ACCUM (ACCUM whenever credit>0):
  - Coin edge with credit<max: credit+1 and accepted=1. With credit=max: credit unchanged and coin_reject=1.
  - Vend edge with sel!=0 and credit>=PRICE: product<=sel, credit<=credit-PRICE, disp_req<=1, go to DISPENSE. Otherwise the vend edge is ignored with no output change.
  - Coin and valid vend in the same cycle: both are applied, credit_next=credit-PRICE+1, accepted=1. The saturation check uses the pre-vend credit.
  - Cancel edge with credit>0: go to CHANGE. Cancel with credit=0 is ignored.
  - Cancel and coin in the same cycle: cancel wins, coin_reject=1. Cancel beats vend.
- DISPENSE:
  - disp_req stays held at 1 and a timeout counter counts up from 0.
  - disp_done=1: disp_req<=0, then go to CHANGE if credit>0, else IDLE.
  - Counter reaching TIMEOUT without disp_done: disp_req<=0, fault<=1, go to FAULT.
  - Coin edges produce coin_reject. Vend and cancel are ignored.
- CHANGE:
  - change_out alternates CHG_PULSE cycles high then CHG_PULSE cycles low, starting high in the first CHANGE cycle.
  - credit decrements by 1 at the end of each high phase.
  - After the low phase that follows credit reaching 0: go to IDLE.
  - Coin edges produce coin_reject. Vend and cancel are ignored.
- FAULT:
  - Sticky until rst_n.
  - credit and product hold; disp_req=0, change_out=0.
  - Coin edges produce coin_reject.
- busy is a combinational decode of state.
- accepted and coin_reject are registered and never both high.
- disp_done outside DISPENSE is ignored.
- Reset mid-DISPENSE or mid-CHANGE aborts the transaction immediately: all outputs go to 0 in the next cycle and credit is lost.

Optional Feature:
- Macro: VEND_INPUT_SYNC_EN.
- Defined: coin, vend, cancel and disp_done each pass through a 2-flop synchronizer, reset to 0, before edge detection and FSM use. All input-to-response latencies increase by 2 cycles.
- Undefined: inputs feed the edge detectors and FSM directly, with the latency given above.

Test Plan:
- Parameters for all scenarios: PRICE=3, CHG_PULSE=4, TIMEOUT=16, macro undefined.
- Coin saturation: 8 coin edges from reset -> credit=7; accepted pulses 7 times; coin_reject pulses once on the 8th edge.
- Vend with change: 5 coins, sel=2, vend edge -> product=2, credit=2, disp_req=1. disp_done pulse -> disp_req=0 next cycle. change_out pulses high 2 times for 4 cycles each; credit reaches 0; state returns to IDLE; busy=0.
- Rejected vends: 2 coins then vend with sel=5 -> no disp_req, credit=2. 3 coins then vend with sel=0 -> ignored, credit=3.
- Simultaneous events: credit=3, coin and vend edges in the same cycle -> credit=1, accepted=1, disp_req=1. Cancel and coin in the same cycle at credit=2 -> CHANGE, coin_reject=1, 2 change pulses.
- Timeout: vend with disp_done held 0 -> after 16 cycles disp_req=0 and fault=1. Further coins give coin_reject. Only rst_n clears fault.
- Reset and ena: rst_n=0 during the second change pulse -> all outputs 0 and credit=0 in the next cycle. ena=0 for 10 cycles mid-CHANGE -> change_out and credit frozen, resuming exactly where they stopped.
